// File: rtl/repeat_sum_pkg.sv
// repeat_sum_pkg: shared constants, decimal power table and FSM state codes
package repeat_sum_pkg;
  localparam int MAX_K = 6;
  localparam int ACC_W = 64;
  localparam logic [40:0] POW10 [0:MAX_K] = '{
    41'd1, 41'd10, 41'd100, 41'd1000, 41'd10000, 41'd100000, 41'd1000000
  };
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_SETUP   = 4'd1;
  localparam state_t S_HI_REQ  = 4'd2;
  localparam state_t S_HI_WAIT = 4'd3;
  localparam state_t S_LO_REQ  = 4'd4;
  localparam state_t S_LO_WAIT = 4'd5;
  localparam state_t S_ACC1    = 4'd6;
  localparam state_t S_ACC2    = 4'd7;
  localparam state_t S_OUT     = 4'd8;
endpackage

// File: rtl/repeat_sum_seq_series_term.sv
// series_term: clamps quotient bounds to the k-digit window and sums X over it
module series_term (
  input  logic [39:0] ql_i,
  input  logic [39:0] qh_i,
  input  logic [19:0] wlo_i,
  input  logic [19:0] whi_i,
  output logic [40:0] t_o
);
  logic [40:0] a, b, p;
  // a = max(ql+1, wlo), b = min(qh, whi); the product has one even factor so the halving is exact
  always_comb begin
    a = ({1'b0, ql_i} + 41'd1 > {21'd0, wlo_i}) ? {1'b0, ql_i} + 41'd1 : {21'd0, wlo_i};
    b = ({1'b0, qh_i} < {21'd0, whi_i}) ? {1'b0, qh_i} : {21'd0, whi_i};
    p = (a + b) * (b - a + 41'd1);
    t_o = (a <= b) ? {1'b0, p[40:1]} : '0;
  end
endmodule

// File: rtl/repeat_sum_seq.sv
// repeat_sum_seq: sums invalid (doubled-block) IDs in a range via per-k divider requests
module repeat_sum_seq (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [39:0]                         in_lo_i,
  input  logic [39:0]                         in_hi_i,
  output logic                                div_start_o,
  output logic [39:0]                         div_dividend_o,
  output logic [40:0]                         div_divisor_o,
  input  logic [39:0]                         div_quotient_i,
  input  logic                                div_done_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [repeat_sum_pkg::ACC_W-1:0]    out_sum_o
);
  import repeat_sum_pkg::*;
  localparam int KW = $clog2(MAX_K + 1);
  state_t state_q, state_d;
  logic [KW-1:0] k_q;
  logic [39:0] lo_q, hi_q, qh_q, ql_q;
  logic [40:0] m_q, t_q, t;
  logic [19:0] wlo_q, whi_q;
  logic [ACC_W-1:0] acc_q;
  series_term u_term (.ql_i(ql_q), .qh_i(qh_q), .wlo_i(wlo_q), .whi_i(whi_q), .t_o(t));
  assign in_ready_o = (state_q == S_IDLE) & ~rst;
  assign div_start_o = (state_q == S_HI_REQ) | (state_q == S_LO_REQ);
  assign div_dividend_o = (state_q == S_HI_REQ) ? hi_q :
                          (state_q == S_LO_REQ && lo_q != '0) ? lo_q - 40'd1 : '0;
  assign div_divisor_o = m_q;
  assign out_valid_o = (state_q == S_OUT);
  assign out_sum_o = acc_q;
  // next state: every k is visited, waits hold until the divider reports done
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = in_valid_i ? S_SETUP : S_IDLE;
      S_SETUP:   state_d = S_HI_REQ;
      S_HI_REQ:  state_d = S_HI_WAIT;
      S_HI_WAIT: state_d = div_done_i ? S_LO_REQ : S_HI_WAIT;
      S_LO_REQ:  state_d = S_LO_WAIT;
      S_LO_WAIT: state_d = div_done_i ? S_ACC1 : S_LO_WAIT;
      S_ACC1:    state_d = S_ACC2;
      S_ACC2:    state_d = (k_q < KW'(MAX_K)) ? S_SETUP : S_OUT;
      S_OUT:     state_d = out_ready_i ? S_IDLE : S_OUT;
      default:   state_d = S_IDLE;
    endcase
  end
  // state register and datapath: capture range, window setup, quotients, accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      qh_q <= '0;
      ql_q <= '0;
      m_q <= '0;
      t_q <= '0;
      wlo_q <= '0;
      whi_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (in_valid_i) begin
          lo_q <= in_lo_i;
          hi_q <= in_hi_i;
          acc_q <= '0;
          k_q <= KW'(1);
        end
        S_SETUP: begin
          m_q <= POW10[k_q] + 41'd1;
          wlo_q <= POW10[k_q - KW'(1)][19:0];
          whi_q <= POW10[k_q][19:0] - 20'd1;
        end
        S_HI_WAIT: if (div_done_i) qh_q <= div_quotient_i;
        S_LO_WAIT: if (div_done_i) ql_q <= div_quotient_i;
        S_ACC1: t_q <= t;
        S_ACC2: begin
          acc_q <= acc_q + ACC_W'(t_q) * ACC_W'(m_q);
          if (k_q < KW'(MAX_K)) k_q <= k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/repeat_sum_seq.md
# repeat_sum_seq

Sequencer directly upstream of the 40-bit restoring divider in the day-2 datapath. It accepts one ID range [lo, hi] per handshake and finds every "invalid" ID in it, meaning a k-digit block X written twice, so ID = X·(10^k+1). For each k = 1..MAX_K it issues two divide requests (floor(hi/m), floor((lo−1)/m)) and clamps the quotients to the k-digit window. It then adds the closed-form arithmetic-series sum to a per-range accumulator and emits that accumulator downstream.

## Interface
- MAX_K, 6: largest half-length in digits. 2·MAX_K digits must fit in 40 bits.
- ACC_W, 64: accumulator and output width.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  range available
- in_ready  out  1  high only in IDLE
- in_lo  in  40  range low bound, inclusive
- in_hi  in  40  range high bound, inclusive. in_lo ≤ in_hi is guaranteed by the source.
- div_start  out  1  one-cycle request pulse to the divider
- div_dividend  out  40  valid while div_start is high
- div_divisor  out  41  m = 10^k+1, never zero
- div_quotient  in  40  sampled only when div_done = 1 in a WAIT state
- div_done  in  1  one-cycle divider completion pulse
- out_valid  out  1  range sum available
- out_ready  in  1  downstream accept
- out_sum  out  ACC_W  sum of all invalid IDs in the range

## Operation
- States:
  - IDLE → SETUP → HI_REQ → HI_WAIT → LO_REQ → LO_WAIT → ACC1 → ACC2.
  - ACC2 goes to SETUP with k+1 if k < MAX_K, otherwise to OUT.
  - OUT goes to IDLE.
- IDLE: when in_valid is high, latch lo and hi, clear acc, set k = 1.
- SETUP: load m = POW10[k]+1, wlo = POW10[k−1], whi = POW10[k]−1 from the package table.
- HI_REQ: div_start = 1, dividend = hi.
- HI_WAIT: hold until div_done, then latch qh.
- LO_REQ: div_start = 1, dividend = (lo == 0) ? 0 : lo−1.
- LO_WAIT: hold until div_done, then latch ql.
- ACC1:
  - a = max(ql+1, wlo), b = min(qh, whi).
  - If a ≤ b: t = ((a+b)·(b−a+1)) >> 1. Otherwise t = 0.
  - The shift is exact because one factor is always even.
- ACC2: acc += t·m.
- OUT: out_valid = 1 and out_sum = acc. Hold both stable until out_ready is high.
- Width rules:
  - a and b are ≤ 20 bits after clamping.
  - (a+b)·n is ≤ 41 bits.
  - t·m is ≤ 61 bits.
  - Accumulation is unsigned, with no overflow for legal inputs.
- All k are always iterated; there is no early exit, even when k contributes 0. This keeps latency data-independent except for divider time.
- div_done outside HI_WAIT or LO_WAIT is ignored.
- Reset values: in_ready = 0, div_start = 0, div_dividend = 0, div_divisor = 0, out_valid = 0, out_sum = 0. State = IDLE, which drives in_ready = 1 from the first cycle after reset.

## Timing
- Input handshake: in_valid && in_ready in IDLE. Data is captured at that edge, and in_ready drops the next cycle.
- The REQ states last exactly 1 cycle. The divider accepts start only when it is idle, which is guaranteed because requests are issued only after the previous done.
- div_done drops one cycle after its pulse, so LO_WAIT never sees a stale HI done.
- Latency per range = 2 + MAX_K·(5 + 2·D), where D is divider cycles from start to done (42 for the current divider). With MAX_K = 6, this is 536 cycles.
- Output handshake: transfer occurs on out_valid && out_ready. out_valid deasserts the next cycle. There is no combinational path from out_ready to in_ready.
- Reset mid-range, including during a divider wait: return to IDLE next cycle and discard acc. The divider shares rst, so no orphaned done can arrive.

## Structure
- Package repeat_sum_pkg holds:
  - the POW10 table, 41-bit entries for indices 0..MAX_K;
  - the state enum;
  - the ACC_W constant.
- Sub-module series_term: combinational a/b clamp and t computation, used by ACC1. The t·m multiply and accumulation stay in the top module.
- The divider is instantiated beside this block in the day-2 top, not inside it.

## Test plan
- [11, 22] → out_sum = 33 (11 + 22).
- [95, 115] → 99. [998, 1012] → 1010.
- [1188511880, 1188511890] → 1188511885. [222220, 222224] → 222222.
- [0, 0] → 0, with no lo−1 underflow. [1, 99] → 495.
- out_ready held low for 20 cycles in OUT → out_sum stable and in_ready low; release → exactly one transfer.
- rst pulsed during the k = 3 LO_WAIT, then [11, 22] applied → 33, no residue from the aborted range.
